axis_interp_arbiter: RTL and testbench

Round-robin scheduler that shares one sample-and-hold interpolating output stream between NUM_CH AXI4-Stream sources. It accepts one sample from the granted channel and repeats it for that channel's configured count plus one beats. Each beat is tagged with the source channel ID, and the last repeat is marked. It sits between per-channel decimated/ADC sample streams and the single downstream DAC/processing path.

---
 rtl/axis_interp_arbiter_if.sv | 36 +++
 rtl/axis_interp_arbiter.sv | 146 ++++++++++++++
 tb/tb_axis_interp_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_interp_arbiter_if.sv
// Bus bundle for axis_interp_arbiter: the NUM_CH upstream sample streams
// (packed side by side) and the single downstream interpolated stream.
//   s_axis_tdata  : NUM_CH*AXIS_TDATA_WIDTH, channel i at [i*W +: W]
//   s_axis_tvalid : NUM_CH per-channel valid
//   s_axis_tready : NUM_CH per-channel ready, at most one bit high
//   m_axis_tdata  : held sample
//   m_axis_tvalid : output valid
//   m_axis_tready : downstream ready
//   m_axis_tuser  : source channel index of the current sample
//   m_axis_tlast  : final repeat beat
// Modport slave is the arbiter's view; modport master is the surrounding
// environment (sources + sink).
interface axis_interp_arbiter_if #(
   parameter int unsigned AXIS_TDATA_WIDTH = 32,
   parameter int unsigned NUM_CH           = 4,
   parameter int unsigned CH_ID_WIDTH      = 2
);
   logic [NUM_CH*AXIS_TDATA_WIDTH-1:0] s_axis_tdata;
   logic [NUM_CH-1:0]                  s_axis_tvalid;
   logic [NUM_CH-1:0]                  s_axis_tready;
   logic [AXIS_TDATA_WIDTH-1:0]        m_axis_tdata;
   logic                               m_axis_tvalid;
   logic                               m_axis_tready;
   logic [CH_ID_WIDTH-1:0]             m_axis_tuser;
   logic                               m_axis_tlast;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
   );
endinterface

// File: rtl/axis_interp_arbiter.sv
// Round-robin arbiter feeding one sample-and-hold interpolating stream.
// A sample taken from the granted channel is repeated cfg_data[ch]+1 times,
// tagged with the channel index; the last repeat carries tlast.
// Ports:
//   aclk, aresetn : clock, synchronous active-low reset
//   cfg_data      : per-channel repeat count, channel i at [i*CNTR_WIDTH +: CNTR_WIDTH]
//   cfg_enable    : per-channel grant mask
//   axis          : stream bundle (axis_interp_arbiter_if.slave)
//   sts_busy      : high while a sample is being repeated
// Optional feature: define AXIS_INTERP_ARB_FASTGRANT_EN to grant the next
// sample on the final beat, removing the idle cycle between bursts.
module axis_interp_arbiter #(
   parameter int unsigned AXIS_TDATA_WIDTH = 32,
   parameter int unsigned CNTR_WIDTH       = 32,
   parameter int unsigned NUM_CH           = 4,
   parameter int unsigned CH_ID_WIDTH      = 2
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic [NUM_CH*CNTR_WIDTH-1:0] cfg_data,
   input  logic [NUM_CH-1:0]            cfg_enable,
   axis_interp_arbiter_if.slave         axis,
   output logic                         sts_busy
);

   typedef enum logic [0:0] {IDLE, SEND} state_t;

   state_t                      state, state_nxt;
   logic [CH_ID_WIDTH-1:0]      rr_ptr, id_reg, id_next, base, gnt;
   logic [CNTR_WIDTH-1:0]       cntr, len_reg, sel_len;
   logic [AXIS_TDATA_WIDTH-1:0] data_reg, sel_data;
   logic [NUM_CH-1:0]           req;
   logic [31:0]                 off, best;
   logic                        gnt_vld, take, cntr_inc, ptr_upd;

   assign req     = axis.s_axis_tvalid & cfg_enable;
   assign id_next = (id_reg == CH_ID_WIDTH'(NUM_CH - 1)) ? '0 : id_reg + CH_ID_WIDTH'(1);

   // Search start: rr_ptr when idle; on the final beat the pointer the burst is about to set
   always_comb begin
      base = rr_ptr;
`ifdef AXIS_INTERP_ARB_FASTGRANT_EN
      if (state == SEND) base = id_next;
`endif
   end

   // Requesting channel with the smallest circular distance from base wins
   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      best    = NUM_CH;
      off     = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         off = (c >= 32'(base)) ? c - 32'(base) : c + NUM_CH - 32'(base);
         if (req[c] && (off < best)) begin
            best    = off;
            gnt     = CH_ID_WIDTH'(c);
            gnt_vld = 1'b1;
         end
      end
   end

   // Payload and repeat count of the granted channel
   always_comb begin
      sel_data = '0;
      sel_len  = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (gnt == CH_ID_WIDTH'(c)) begin
            sel_data = axis.s_axis_tdata[c*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
            sel_len  = cfg_data[c*CNTR_WIDTH +: CNTR_WIDTH];
         end
      end
   end

   // Next state and datapath controls; no grant is issued while reset is held
   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      cntr_inc  = 1'b0;
      ptr_upd   = 1'b0;
      case (state)
         IDLE: begin
            if (gnt_vld && aresetn) begin
               take      = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (axis.m_axis_tready) begin
               if (cntr < len_reg) begin
                  cntr_inc = 1'b1;
               end else begin
                  ptr_upd   = 1'b1;
                  state_nxt = IDLE;
`ifdef AXIS_INTERP_ARB_FASTGRANT_EN
                  if (gnt_vld && aresetn) begin
                     take      = 1'b1;
                     state_nxt = SEND;
                  end
`endif
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Ready is a one-cycle pulse on the granted channel only
   always_comb begin
      axis.s_axis_tready = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         axis.s_axis_tready[c] = take && (gnt == CH_ID_WIDTH'(c));
      end
   end

   // State, pointer and captured sample
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         cntr     <= '0;
         len_reg  <= '0;
         data_reg <= '0;
         id_reg   <= '0;
      end else begin
         state <= state_nxt;
         if (ptr_upd) rr_ptr <= id_next;
         if (take) begin
            data_reg <= sel_data;
            id_reg   <= gnt;
            len_reg  <= sel_len;
            cntr     <= '0;
         end else if (cntr_inc) begin
            cntr <= cntr + CNTR_WIDTH'(1);
         end
      end
   end

   // Output stream is decoded purely from registered state
   assign axis.m_axis_tvalid = (state == SEND);
   assign axis.m_axis_tlast  = (state == SEND) && (cntr == len_reg);
   assign axis.m_axis_tdata  = data_reg;
   assign axis.m_axis_tuser  = id_reg;
   assign sts_busy           = (state == SEND);

endmodule

// File: tb/tb_axis_interp_arbiter.sv
// Self-checking bench for axis_interp_arbiter: a transaction-level model
// (queue of pending output beats + round-robin pointer) checked every cycle,
// plus hand-computed expectations for each directed scenario.
module tb_axis_interp_arbiter;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 32;
   localparam int unsigned N  = 4;
   localparam int unsigned IW = 2;
`ifdef AXIS_INTERP_ARB_FASTGRANT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   logic [N*CW-1:0] cfg_data = '0;
   logic [N-1:0]    cfg_enable = '1;
   logic            sts_busy;

   axis_interp_arbiter_if #(.AXIS_TDATA_WIDTH(DW), .NUM_CH(N), .CH_ID_WIDTH(IW)) axis ();

   axis_interp_arbiter #(
      .AXIS_TDATA_WIDTH(DW), .CNTR_WIDTH(CW), .NUM_CH(N), .CH_ID_WIDTH(IW)
   ) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .cfg_data   (cfg_data),
      .cfg_enable (cfg_enable),
      .axis       (axis.slave),
      .sts_busy   (sts_busy)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [DW-1:0] data;
      int            ch;
   } beat_t;

   beat_t         mq[$];
   int            ptr = 0;
   int            gr_log[$];
   logic [DW-1:0] src_q[N][$];
   logic [N-1:0]  drv_hs;
   bit            started = 1'b0;
   int            obs_beats, obs_last, run, max_run;
   int            obs_rdy[N];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick(input int b, input logic [N-1:0] r);
      for (int k = 0; k < int'(N); k++) begin
         int c = (b + k) % int'(N);
         if (r[c]) return c;
      end
      return -1;
   endfunction

   // Upstream sources: present queue heads, pop on handshake
   always begin
      @(negedge aclk);
      drv_hs = axis.s_axis_tvalid & axis.s_axis_tready;
      @(posedge aclk);
      #2;
      for (int c = 0; c < int'(N); c++) begin
         if (drv_hs[c] && src_q[c].size() != 0) void'(src_q[c].pop_front());
         axis.s_axis_tvalid[c] = (src_q[c].size() != 0);
         axis.s_axis_tdata[c*DW +: DW] = (src_q[c].size() != 0) ? src_q[c][0] : '0;
      end
   end

   // Compare DUT against the model each cycle, then advance the model
   always @(negedge aclk) begin
      int           g;
      int unsigned  len;
      logic [N-1:0] req, exp_rdy;
      beat_t        b;
      bit           lastb;
      if (started) begin
         req = axis.s_axis_tvalid & cfg_enable;
         g = -1;
         if (aresetn) begin
            if (mq.size() == 0) g = pick(ptr, req);
            else if (FAST && mq.size() == 1 && axis.m_axis_tready) g = pick((mq[0].ch + 1) % int'(N), req);
         end
         exp_rdy = '0;
         if (g >= 0) exp_rdy[g] = 1'b1;
         chk("s_tready", axis.s_axis_tready, exp_rdy);
         chk("m_tvalid", axis.m_axis_tvalid, mq.size() != 0);
         chk("sts_busy", sts_busy, mq.size() != 0);
         if (mq.size() != 0) begin
            chk("m_tdata", axis.m_axis_tdata, mq[0].data);
            chk("m_tuser", axis.m_axis_tuser, mq[0].ch);
            chk("m_tlast", axis.m_axis_tlast, mq.size() == 1);
         end
         if (axis.m_axis_tvalid && axis.m_axis_tready) begin
            obs_beats++;
            if (axis.m_axis_tlast) obs_last++;
         end
         for (int c = 0; c < int'(N); c++) if (axis.s_axis_tready[c]) obs_rdy[c]++;
         run = axis.m_axis_tvalid ? run + 1 : 0;
         if (run > max_run) max_run = run;
         if (!aresetn) begin
            mq.delete();
            ptr = 0;
         end else begin
            if (mq.size() != 0 && axis.m_axis_tready) begin
               lastb = (mq.size() == 1);
               b = mq.pop_front();
               if (lastb) ptr = (b.ch + 1) % int'(N);
            end
            if (g >= 0) begin
               len = cfg_data[g*CW +: CW];
               b.data = axis.s_axis_tdata[g*DW +: DW];
               b.ch = g;
               for (longint k = 0; k <= longint'(len); k++) mq.push_back(b);
               gr_log.push_back(g);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic clear_obs();
      obs_beats = 0;
      obs_last = 0;
      run = 0;
      max_run = 0;
      for (int c = 0; c < int'(N); c++) obs_rdy[c] = 0;
      gr_log.delete();
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      for (int c = 0; c < int'(N); c++) src_q[c].delete();
      axis.m_axis_tready = 1'b1;
      cfg_data = '0;
      cfg_enable = '1;
      cyc(2);
      aresetn = 1'b1;
      clear_obs();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tvalid"}, axis.m_axis_tvalid, 0);
      chk({tag, "_tlast"}, axis.m_axis_tlast, 0);
      chk({tag, "_tdata"}, axis.m_axis_tdata, 0);
      chk({tag, "_tuser"}, axis.m_axis_tuser, 0);
      chk({tag, "_busy"}, sts_busy, 0);
      chk({tag, "_sready"}, axis.s_axis_tready, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      int n;
      int exp_rr[5];
      int exp_mask[4];
      bit pat[5];
      axis.m_axis_tready = 1'b1;
      clear_obs();
      cyc(2);
      started = 1'b1;
      chk_reset_outputs("por");
      aresetn = 1'b1;
      clear_obs();

      // Single channel: 0xA5 repeated 4 times
      cfg_data[0*CW +: CW] = 3;
      src_q[0].push_back(32'hA5);
      cyc(10);
      chk("t1_beats", obs_beats, 4);
      chk("t1_last", obs_last, 1);
      chk("t1_rdy0", obs_rdy[0], 1);
      chk("t1_grants", gr_log.size(), 1);
      chk("t1_gnt0", (gr_log.size() > 0) ? gr_log[0] : -1, 0);
      chk("t1_run", max_run, 4);

      // Round robin, all channels valid, single-beat bursts
      do_reset();
      src_q[0].push_back(32'h100);
      src_q[0].push_back(32'h104);
      src_q[1].push_back(32'h101);
      src_q[2].push_back(32'h102);
      src_q[3].push_back(32'h103);
      cyc(16);
      exp_rr = '{0, 1, 2, 3, 0};
      chk("t2_grants", gr_log.size(), 5);
      for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), (gr_log.size() > i) ? gr_log[i] : -1, exp_rr[i]);
      chk("t2_beats", obs_beats, 5);
      chk("t2_last", obs_last, 5);

      // Backpressure with mid-burst cfg change: still 3 beats
      do_reset();
      cfg_data[1*CW +: CW] = 2;
      src_q[1].push_back(32'h11);
      cyc(1);
      pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         axis.m_axis_tready = pat[i];
         if (i == 1) cfg_data[1*CW +: CW] = 9;
         cyc(1);
      end
      axis.m_axis_tready = 1'b1;
      cyc(6);
      chk("t3_beats", obs_beats, 3);
      chk("t3_last", obs_last, 1);
      chk("t3_grants", gr_log.size(), 1);

      // Grant mask 1010
      do_reset();
      cfg_enable = 4'b1010;
      for (int c = 0; c < int'(N); c++) begin
         src_q[c].push_back(32'h200 + 32'(c));
         src_q[c].push_back(32'h210 + 32'(c));
      end
      cyc(20);
      exp_mask = '{1, 3, 1, 3};
      chk("t4_grants", gr_log.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("t4_order%0d", i), (gr_log.size() > i) ? gr_log[i] : -1, exp_mask[i]);
      chk("t4_rdy0", obs_rdy[0], 0);
      chk("t4_rdy2", obs_rdy[2], 0);

      // Reset after the second beat of a 6-beat burst
      do_reset();
      cfg_data[0*CW +: CW] = 5;
      src_q[0].push_back(32'h50);
      src_q[0].push_back(32'h51);
      src_q[1].push_back(32'h60);
      n = 0;
      while (obs_beats < 2 && n < 50) begin
         cyc(1);
         n++;
      end
      chk("t5_reach_beat2", obs_beats >= 2, 1);
      aresetn = 1'b0;
      cyc(1);
      chk_reset_outputs("t5_rst");
      cyc(1);
      aresetn = 1'b1;
      clear_obs();
      cyc(20);
      chk("t5_grants", gr_log.size(), 2);
      chk("t5_first", (gr_log.size() > 0) ? gr_log[0] : -1, 0);
      chk("t5_beats", obs_beats, 7);

      // Back-to-back bursts: bubble only without fast grant
      do_reset();
      cfg_data[0*CW +: CW] = 1;
      cfg_data[1*CW +: CW] = 1;
      src_q[0].push_back(32'h70);
      src_q[1].push_back(32'h71);
      cyc(12);
      chk("t6_beats", obs_beats, 4);
      chk("t6_run", max_run, FAST ? 4 : 2);
      chk("t6_grants", gr_log.size(), 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
